sixtyfour_bit_result_queue: RTL and testbench
=============================================

# sixtyfour_bit_result_queue

Registered result stage directly downstream of `sixtyfour_bit_adder`. It captures the adder's combinational outputs `S`/`Cout` together with the operand sign bits into a small FIFO, and derives per-result status flags: signed overflow and zero. It presents the results to the consumer over a valid/ready handshake. It decouples the adder's combinational path from downstream logic and counts accepted results.

## Interface
Parameters:
- `WIDTH`, 64: operand/sum width; must match the adder.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.

Ports:
- `clk`, input, 1: rising-edge clock; single clock domain.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `in_valid`, input, 1: the adder outputs and operands are valid this cycle.
- `in_ready`, output, 1: the queue can accept an entry.
- `A`, input, WIDTH: adder operand A; only `A[WIDTH-1]` is used.
- `B`, input, WIDTH: adder operand B; only `B[WIDTH-1]` is used.
- `S`, input, WIDTH: adder sum.
- `Cout`, input, 1: adder carry-out.
- `out_valid`, output, 1: the head entry is valid.
- `out_ready`, input, 1: the consumer takes the head entry.
- `out_sum`, output, WIDTH: head sum.
- `out_cout`, output, 1: head carry-out.
- `out_ovf`, output, 1: head signed overflow.
- `out_zero`, output, 1: head sum equals 0.
- `result_cnt`, output, 16: number of accepted entries.
- `out_par`, output, 1: even parity of the head sum. Present only with `SUM_PARITY_EN`.

## Operation
- Push occurs when `in_valid && in_ready`. The entry written is {`S`, `Cout`, ovf, zero}.
  - ovf = (`A[W-1]` == `B[W-1]`) && (`S[W-1]` != `A[W-1]`), computed from the presented values.
  - zero = (`S` == 0).
- Pop occurs when `out_valid && out_ready`.
- Pointers `wr_ptr` and `rd_ptr` are log2(DEPTH) bits wide and wrap modulo DEPTH. The occupancy counter `occ` is log2(DEPTH)+1 bits.
- `in_ready` = (`occ` != DEPTH).
  - It depends on state only, never on `out_ready`.
  - When full, a simultaneous pop does not allow a same-cycle push.
- `out_valid` = (`occ` != 0).
- When `out_valid` = 1, the head outputs are driven directly from storage at `rd_ptr`. When `out_valid` = 0, `out_sum`, `out_cout`, `out_ovf`, `out_zero` and `out_par` are forced to 0.
- Simultaneous push and pop with 0 < `occ` < DEPTH: both pointers advance and `occ` is unchanged.
- Push while empty with `out_ready` = 1: the push only is performed. There is no combinational pass-through.
- `result_cnt` increments by 1 on each push and wraps from 0xFFFF to 0x0000.
- Results leave strictly in FIFO order. Values are stored unmodified, with no saturation.

## Timing
- Reset (`rst_n` = 0 at a rising edge): `occ`, `wr_ptr`, `rd_ptr` and `result_cnt` are cleared to 0. The resulting output values are:
  - `in_ready` = 1
  - `out_valid` = 0
  - all data outputs = 0
- Reset during operation discards all stored entries at that edge. A push or pop presented in that same cycle is ignored.
- Latency: an entry pushed at edge N is visible with `out_valid` = 1 in the cycle after edge N, provided the queue was empty.
- Throughput is 1 entry per cycle when the consumer holds `out_ready` = 1.
- Storage contents are not reset; only the pointers are. The output masking keeps the outputs deterministic.
- `in_ready` and `out_valid` are functions of registered state only and carry no combinational input-to-output path.

## Configuration
- With `SUM_PARITY_EN` defined:
  - each entry stores an extra bit, ^`S` (XOR reduction);
  - the `out_par` port exists and carries the head's bit, or 0 when empty.
- Without it, the `out_par` port and its storage are absent, and all other behaviour is identical.

## Test plan
1. Reset check: hold `rst_n` = 0 for 2 cycles, then release. Required: `in_ready` = 1, `out_valid` = 0, `result_cnt` = 0, `out_sum` = 0.
2. Signed overflow: push `A` = 0x7FFF_FFFF_FFFF_FFFF, `B` = 1, `S` = 0x8000_0000_0000_0000, `Cout` = 0. Required next cycle: `out_valid` = 1, `out_ovf` = 1, `out_zero` = 0, `out_cout` = 0.
3. Zero with carry: push `A` = 0xFFFF_FFFF_FFFF_FFFF, `B` = 1, `S` = 0, `Cout` = 1. Required: `out_zero` = 1, `out_cout` = 1, `out_ovf` = 0. With the macro defined, `out_par` = 0.
4. Full queue: hold `out_ready` = 0 and push 5 entries with sums 1..5. Required:
   - `in_ready` = 0 after the 4th push and the 5th is not accepted;
   - `result_cnt` = 4;
   - after raising `out_ready`, sums pop in the order 1, 2, 3, 4.
5. Streaming: hold `in_valid` and `out_ready` at 1 for 10 cycles with sums 10..19. Required: `occ` stays at 1 after the first push, the output sequence is 10..19 with no gaps, and `result_cnt` = 10.
6. Reset mid-operation: with 3 entries queued, assert `rst_n` = 0 for one edge while a push is presented. Required: `out_valid` = 0 and `result_cnt` = 0 afterwards, and the queued entries never appear.

Source files
------------

// File: rtl/sixtyfour_bit_result_queue.sv
// sixtyfour_bit_result_queue
// Registered result stage behind sixtyfour_bit_adder. It captures the sum,
// the carry-out, a signed-overflow flag and a zero flag into a small FIFO,
// and hands entries to the consumer over a valid/ready handshake.
// Optional feature macro: SUM_PARITY_EN. When it is defined, each entry also
// stores the even parity of the sum, presented on out_par.
module sixtyfour_bit_result_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] S,
    input  logic             Cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [15:0]      result_cnt
`ifdef SUM_PARITY_EN
    ,
    output logic             out_par
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   OCC_NONE = '0;
    localparam logic [15:0]   CNT_ONE  = 16'd1;

    // Signed overflow of a two's-complement add: both operands share a sign
    // and the sum's sign differs from it.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Even parity of the sum (XOR reduction).
    function automatic logic sum_parity(input logic [WIDTH-1:0] sum);
        return ^sum;
    endfunction

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    // Entry storage, deliberately not reset; outputs are masked while empty.
    logic [WIDTH-1:0] sum_mem  [DEPTH];
    logic             cout_mem [DEPTH];
    logic             ovf_mem  [DEPTH];
    logic             zero_mem [DEPTH];
`ifdef SUM_PARITY_EN
    logic             par_mem  [DEPTH];
`endif

    logic push;
    logic pop;
    logic new_ovf;
    logic new_zero;

    // Only the operand sign bits feed the flags; the rest of A and B is
    // intentionally ignored.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{A[WIDTH-2:0], B[WIDTH-2:0]};

    // Handshake status comes from registered occupancy only, so there is no
    // combinational path from any input to in_ready or out_valid. A full
    // queue refuses a push even while it is being popped.
    assign in_ready  = (occ != OCC_FULL);
    assign out_valid = (occ != OCC_NONE);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign new_ovf  = signed_ovf(A[WIDTH-1], B[WIDTH-1], S[WIDTH-1]);
    assign new_zero = (S == '0);

    // Pointer, occupancy and result-count update; reset discards all entries
    // and ignores any push or pop presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            result_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                result_cnt <= result_cnt + CNT_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Write the accepted entry at wr_ptr; values are stored unmodified.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            sum_mem[wr_ptr]  <= S;
            cout_mem[wr_ptr] <= Cout;
            ovf_mem[wr_ptr]  <= new_ovf;
            zero_mem[wr_ptr] <= new_zero;
`ifdef SUM_PARITY_EN
            par_mem[wr_ptr]  <= sum_parity(S);
`endif
        end
    end

    // Present the head entry straight from storage, forced to zero when empty.
    always_comb begin
        out_sum  = '0;
        out_cout = 1'b0;
        out_ovf  = 1'b0;
        out_zero = 1'b0;
`ifdef SUM_PARITY_EN
        out_par  = 1'b0;
`endif
        if (out_valid) begin
            out_sum  = sum_mem[rd_ptr];
            out_cout = cout_mem[rd_ptr];
            out_ovf  = ovf_mem[rd_ptr];
            out_zero = zero_mem[rd_ptr];
`ifdef SUM_PARITY_EN
            out_par  = par_mem[rd_ptr];
`endif
        end
    end

`ifndef SUM_PARITY_EN
    // Parity helper is only consumed by the optional parity storage.
    logic unused_parity;
    assign unused_parity = sum_parity('0);
`endif

endmodule

// File: tb/tb_sixtyfour_bit_result_queue.sv
// Scoreboard bench for sixtyfour_bit_result_queue: the driver queues the
// hand-computed expected entry for every push it expects to be accepted, and
// an independent monitor compares each entry the DUT hands out.
module tb_sixtyfour_bit_result_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic [63:0] S;
    logic        Cout;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic [15:0] result_cnt;
`ifdef SUM_PARITY_EN
    logic        out_par;
`endif

    sixtyfour_bit_result_queue #(.WIDTH(64), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .S          (S),
        .Cout       (Cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .result_cnt (result_cnt)
`ifdef SUM_PARITY_EN
        ,
        .out_par    (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        par;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   pops   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: every handshake the DUT completes must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: got sum 0x%0h, required no entry", out_sum);
            end else begin
                e = exp_q.pop_front();
                check("pop_sum",  out_sum,  e.sum);
                check("pop_cout", {63'b0, out_cout}, {63'b0, e.cout});
                check("pop_ovf",  {63'b0, out_ovf},  {63'b0, e.ovf});
                check("pop_zero", {63'b0, out_zero}, {63'b0, e.zero});
`ifdef SUM_PARITY_EN
                check("pop_par",  {63'b0, out_par},  {63'b0, e.par});
`endif
            end
        end
    end

    task automatic do_reset(input int cycles);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Present one entry for one edge; queue its expectation if it should be taken.
    task automatic push_one(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] s, input logic c,
                            input logic ovf, input logic zero, input bit accept);
        exp_t e;
        in_valid = 1'b1;
        A = a; B = b; S = s; Cout = c;
        e.sum = s; e.cout = c; e.ovf = ovf; e.zero = zero; e.par = ^s;
        if (accept) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; S = '0; Cout = 1'b0;

        // 1: reset state
        do_reset(2);
        check("rst_in_ready",   {63'b0, in_ready},  64'd1);
        check("rst_out_valid",  {63'b0, out_valid}, 64'd0);
        check("rst_result_cnt", {48'b0, result_cnt}, 64'd0);
        check("rst_out_sum",    out_sum, 64'd0);
        check("rst_out_flags",  {61'b0, out_cout, out_ovf, out_zero}, 64'd0);
`ifdef SUM_PARITY_EN
        check("rst_out_par",    {63'b0, out_par}, 64'd0);
`endif

        // 2: signed overflow, visible one cycle after the push
        out_ready = 1'b1;
        push_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1);
        check("ovf_latency_valid", {63'b0, out_valid}, 64'd1);
        check("ovf_flag",          {63'b0, out_ovf},   64'd1);
        check("ovf_zero_flag",     {63'b0, out_zero},  64'd0);
        @(posedge clk); #1;
        check("ovf_drained", {63'b0, out_valid}, 64'd0);

        // 3: zero sum with carry
        push_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1, 1);
        check("zero_flag", {63'b0, out_zero}, 64'd1);
        check("zero_cout", {63'b0, out_cout}, 64'd1);
        check("zero_ovf",  {63'b0, out_ovf},  64'd0);
`ifdef SUM_PARITY_EN
        check("zero_par",  {63'b0, out_par},  64'd0);
`endif
        @(posedge clk); #1;
        check("cnt_after_two", {48'b0, result_cnt}, 64'd2);

        // 4: fill to full with out_ready low; the fifth push is refused
        do_reset(1);
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            push_one(64'd0, 64'd0, 64'(i), 1'b0, 1'b0, 1'b0, 1);
        check("full_in_ready", {63'b0, in_ready}, 64'd0);
        push_one(64'd0, 64'd0, 64'd5, 1'b0, 1'b0, 1'b0, 0);
        check("full_result_cnt", {48'b0, result_cnt}, 64'd4);
        check("full_head_sum",   out_sum, 64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("full_drained_valid", {63'b0, out_valid}, 64'd0);
        check("full_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // 5: streaming at one entry per cycle
        do_reset(1);
        out_ready = 1'b1;
        pops = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            A = '0; B = '0; S = 64'(10 + i); Cout = 1'b0;
            e.sum = S; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0; e.par = ^S;
            exp_q.push_back(e);
            @(posedge clk); #1;
            check("stream_occ",   64'(dut.occ), 64'd1);
            check("stream_valid", {63'b0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream_result_cnt", {48'b0, result_cnt}, 64'd10);
        check("stream_pops",       64'(pops), 64'd10);
        check("stream_empty",      {63'b0, out_valid}, 64'd0);

        // 6: reset with three entries queued and a push presented
        do_reset(1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_one(64'd0, 64'd0, 64'(100 + i), 1'b0, 1'b0, 1'b0, 1);
        check("pre_reset_cnt", {48'b0, result_cnt}, 64'd3);
        in_valid = 1'b1; S = 64'd99; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        check("midrst_out_valid",  {63'b0, out_valid}, 64'd0);
        check("midrst_result_cnt", {48'b0, result_cnt}, 64'd0);
        check("midrst_in_ready",   {63'b0, in_ready},  64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midrst_stays_empty", {63'b0, out_valid}, 64'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
